// File: rtl/div_result_uart_tx.sv
// div_result_uart_tx: buffers divider results in a small FIFO
// and sends each one off-chip as a single 8N1 UART byte.
module div_result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_quot,
  input  logic [3:0]                    in_rem,
  input  logic                          in_dbz,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shreg;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    byte_in;
  logic          push;
  logic          pop;

  // A divide-by-zero collapses to 0xFF; q=15 forces r=0 so no clash.
  assign byte_in = in_dbz ? 8'hFF : {in_quot, in_rem};

  // Readiness is masked during reset so nothing is offered then.
  assign in_ready = rst_n && ena && (fifo_count < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && ena && (fifo_count != '0);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // Storage array needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= byte_in;
    end
  end

  // Circular pointers and occupancy; push+pop leaves count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_uart_tx.sv
// tb_div_result_uart_tx: random and directed stimulus checked
// every cycle against a queue-based UART/FIFO model.
module tb_div_result_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_quot = '0;
  logic [3:0] in_rem = '0;
  logic       in_dbz = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  div_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_quot(in_quot),
    .in_rem(in_rem),
    .in_dbz(in_dbz),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0] mq[$];
  bit         f_act = 1'b0;
  int         f_t = 0;
  logic [7:0] f_byte = '0;

  function automatic logic [7:0] enc(input logic [3:0] q,
                                     input logic [3:0] r,
                                     input logic d);
    return d ? 8'hFF : {q, r};
  endfunction

  function automatic logic exp_tx();
    int slot;
    if (!f_act) return 1'b1;
    slot = f_t / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return f_byte[slot-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      mq.delete();
      f_act = 1'b0;
      f_t   = 0;
    end else begin
      do_push = in_valid && ena && (mq.size() < DEPTH);
      do_pop  = !f_act && ena && (mq.size() != 0);
      if (f_act) begin
        f_t++;
        if (f_t == FLEN) f_act = 1'b0;
      end else if (do_pop) begin
        f_byte = mq.pop_front();
        f_act  = 1'b1;
        f_t    = 0;
      end
      if (do_push) mq.push_back(enc(in_quot, in_rem, in_dbz));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  // Cycle compare against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("tx", int'(tx), int'(exp_tx()));
      check("in_ready", int'(in_ready),
            int'(rst_n && ena && (mq.size() < DEPTH)));
      check("busy", int'(busy), int'(f_act || (mq.size() != 0)));
      check("fifo_count", int'(fifo_count), mq.size());
    end
  end

  // Assumes caller sits at a negedge; returns at a negedge.
  task automatic push(input logic [3:0] q, input logic [3:0] r,
                      input logic d);
    int n = 0;
    in_valid = 1'b1;
    in_quot  = q;
    in_rem   = r;
    in_dbz   = d;
    #1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] exp, input string name);
    int n = 0;
    logic [7:0] b;
    while (tx !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check({name, "_start_timeout"}, 0, 1);
    end else begin
      repeat (CPB / 2) @(negedge clk);
      check({name, "_startbit"}, int'(tx), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      check({name, "_stopbit"}, int'(tx), 1);
      check(name, int'(b), int'(exp));
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    chk_en = 1'b1;
    // 1: reset and idle line
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_count", int'(fifo_count), 0);
    repeat (50) @(negedge clk);

    // 2/3: single results decoded by a UART receiver
    push(4'd3, 4'd2, 1'b0);
    rx_byte(8'h32, "byte_11_3");
    wait_idle(400);
    push(4'd0, 4'd0, 1'b1);
    rx_byte(8'hFF, "byte_dbz");
    wait_idle(400);
    push(4'd15, 4'd0, 1'b0);
    rx_byte(8'hF0, "byte_15_1");
    wait_idle(400);
    push(4'd0, 4'd5, 1'b0);
    rx_byte(8'h05, "byte_5_10");
    wait_idle(400);

    // 4: six back-to-back tuples, backpressure at full
    for (int i = 0; i < 6; i++) begin
      push(4'(i + 1), 4'(i), 1'b0);
      if (i == 4) check("full_count", int'(fifo_count), 4);
    end
    wait_idle(2000);

    // 5: ena low holds queued entries
    push(4'd1, 4'd1, 1'b0);
    push(4'd2, 4'd2, 1'b0);
    push(4'd3, 4'd3, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    ena = 1'b0;
    repeat (FLEN + 20) @(negedge clk);
    check("hold_count", int'(fifo_count), 2);
    check("hold_tx", int'(tx), 1);
    ena = 1'b1;
    @(negedge clk);
    check("resume_tx", int'(tx), 0);
    repeat (4 * CPB) @(negedge clk);
    ena = 1'b0;
    repeat (FLEN + 20) @(negedge clk);
    check("hold2_count", int'(fifo_count), 1);
    ena = 1'b1;
    wait_idle(1000);

    // 6: async reset inside data bit 4
    push(4'd6, 4'd6, 1'b0);
    push(4'd7, 4'd7, 1'b0);
    push(4'd8, 4'd8, 1'b0);
    repeat (5 * CPB + 6) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_tx", int'(tx), 1);
    check("async_count", int'(fifo_count), 0);
    check("async_busy", int'(busy), 0);
    check("async_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("no_frames_busy", int'(busy), 0);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      ena      = ($urandom_range(0, 15) != 0);
      in_valid = ($urandom_range(0, 99) < 4);
      in_quot  = 4'($urandom);
      in_rem   = 4'($urandom);
      in_dbz   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    wait_idle(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_result_uart_tx.md
Name: div_result_uart_tx

Overview:
Downstream consumer of the 4-bit unsigned divider result: accepts {quotient, remainder, divide-by-zero} tuples over a valid/ready handshake and buffers them in a small FIFO. It serialises each result as one 8N1 UART byte on a single output pin. This lets the tile report results off-chip without sampling uo_out every cycle.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; integer ≥ 2.
FIFO_DEPTH, 4, result entries buffered; power of two ≥ 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  tile enable; gates acceptance and frame start.
in_valid  input  1  result tuple present.
in_ready  output  1  block can accept the tuple this cycle.
in_quot  input  4  quotient from divider.
in_rem  input  4  remainder from divider.
in_dbz  input  1  divisor was zero.
tx  output  1  UART line; idle high.
busy  output  1  frame in progress or FIFO non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, async): tx=1, in_ready=0 while asserted, busy=0, fifo_count=0, FSM=IDLE, FIFO pointers and bit/baud counters cleared. Reset mid-frame aborts the frame immediately; tx returns high asynchronously; queued entries are discarded.
- in_ready = ena && (fifo_count < FIFO_DEPTH); combinational from registered state. Push on a rising edge with in_valid && in_ready.
- Byte encoding: in_dbz=0 → {in_quot, in_rem}; in_dbz=1 → 8'hFF regardless of quot/rem. 0xFF is unambiguous because q=15 implies divisor 1 and therefore r=0.
- FIFO: circular, write/read pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop in the same cycle leaves count unchanged. There is no pass-through when full: in_ready is low when count==FIFO_DEPTH, even if a pop occurs that cycle.
- FSM states:
  - IDLE: tx=1. If ena && count≠0, pop the head into the shift register, tx<=0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with tx=bit0.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, 3-bit index. After bit7, go to STOP with tx=1.
  - STOP: hold for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Push into an empty, idle FIFO at edge N: count=1 after N; pop and tx falls after edge N+1.
  - Frame length is 10×CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle (tx high) between the stop bit and the next start bit, so start edges are 10×CLKS_PER_BIT+1 cycles apart.
- tx is registered (glitch-free).
- ena low: no new frame starts and in_ready=0. A frame already in progress completes. The FIFO contents are retained.
- busy = (FSM≠IDLE) || (count≠0).
- fifo_count is registered and updated on the push/pop edge.

Test Plan:
1. Hold rst_n low 2 cycles then release, ena=1 → tx=1, in_ready=1, busy=0, fifo_count=0, no tx activity for 50 cycles.
2. Push q=3, r=2, dbz=0 (11/3), CLKS_PER_BIT=16 → tx low starting 1 cycle after push edge. Bits sampled mid-bit read 0x32 (LSB first 0,1,0,0,1,1,0,0), then stop high. busy drops 160 cycles after tx falls.
3. Push q=0, r=0, dbz=1 (9/0) → byte 0xFF. Push q=15, r=0 (15/1) → 0xF0. Push q=0, r=5 (5/10) → 0x05.
4. Hold in_valid high with 6 distinct tuples → first 4 accepted while the first frame starts (one popped, so a 5th is accepted). in_ready deasserts at fifo_count=4. Bytes are transmitted in push order, each start edge 161 cycles apart.
5. Queue 2 entries with ena=0 → tx stays high, in_ready=0, fifo_count=2. Raise ena → tx falls on the following cycle. Drop ena during bit 3 → current frame completes, second frame does not start.
6. Assert rst_n low during DATA bit 4 with 2 entries queued → tx=1 and fifo_count=0 immediately, without waiting for a clock edge. After release, no further frames are sent.
